// File: rtl/senone_serial_link.sv
// rtl/senone_serial_link.sv - SRAM-to-UART senone streamer with an independent UART word receiver
// Sender FSM feeds a 20-bit (two 8N1 frames) TX shifter; RX assembles byte pairs into rx_nums slots.
module senone_serial_link #(
  parameter int          N_SENONES    = 5,
  parameter logic [20:0] BASE_ADDR    = 21'd0,
  parameter int          CLKS_PER_BIT = 100,
  parameter int          N_RX_NUMS    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_send,
  output logic                      send_done,
  output logic [20:0]               sram_addr,
  output logic                      read_data,
  input  logic                      sram_ready,
  input  logic signed [15:0]        data_in,
  output logic                      tx,
  input  logic                      rx,
  output logic [16*N_RX_NUMS-1:0]   rx_nums,
  output logic                      rx_available
);

  localparam int IW = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam int KW = (N_RX_NUMS > 1) ? $clog2(N_RX_NUMS) : 1;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_SENONES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(N_RX_NUMS - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- sender FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} snd_state_e;

  snd_state_e      snd_state_q, snd_state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     word_q, word_d;
  logic            tx_start;
  logic            tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      snd_state_q <= S_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
    end else begin
      snd_state_q <= snd_state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
    end
  end

  always_comb begin
    snd_state_d = snd_state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    tx_start    = 1'b0;
    case (snd_state_q)
      S_IDLE: begin
        if (start_send) begin
          idx_d       = '0;
          snd_state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sram_ready) begin
          word_d      = data_in;
          snd_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_ready) begin
          tx_start    = 1'b1;
          snd_state_d = S_SEND;
        end
      end
      S_SEND: begin
        // The serializer is already busy on the first SEND cycle, so ready here means the word is out.
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            snd_state_d = S_DONE;
          end else begin
            idx_d       = idx_q + 1'b1;
            snd_state_d = S_REQ;
          end
        end
      end
      S_DONE: snd_state_d = S_IDLE;
      default: snd_state_d = S_IDLE;
    endcase
  end

  assign read_data = (snd_state_q == S_REQ);
  assign send_done = (snd_state_q == S_DONE);
  assign sram_addr = BASE_ADDR + {{(21-IW){1'b0}}, idx_q};

  // ---------------- TX serializer ----------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [4:0]      tx_bit_q, tx_bit_d;
  logic [19:0]     tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_ready = (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          // Two frames sent LSB first from bit 0: MSB byte frame, then LSB byte frame.
          tx_shift_d = {1'b1, word_q[7:0], 1'b0, 1'b1, word_q[15:8], 1'b0};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 5'd19) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d   = tx_bit_q + 5'd1;
            tx_shift_d = {1'b1, tx_shift_q[19:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_d = (tx_state_d == TX_BUSY) ? tx_shift_d[0] : 1'b1;
  end

  assign tx = tx_q;

  // ---------------- RX deserializer and word assembly ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  logic                     rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e                rx_state_q, rx_state_d;
  logic [CW-1:0]            rx_cnt_q, rx_cnt_d;
  logic [2:0]               rx_bit_q, rx_bit_d;
  logic [7:0]               rx_shift_q, rx_shift_d;
  logic [7:0]               rx_msb_q, rx_msb_d;
  logic                     rx_half_q, rx_half_d;
  logic [KW-1:0]            rx_k_q, rx_k_d;
  logic [16*N_RX_NUMS-1:0]  rx_nums_q, rx_nums_d;
  logic                     rx_avail_q, rx_avail_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_msb_q   <= '0;
      rx_half_q  <= 1'b0;
      rx_k_q     <= '0;
      rx_nums_q  <= '0;
      rx_avail_q <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_msb_q   <= rx_msb_d;
      rx_half_q  <= rx_half_d;
      rx_k_q     <= rx_k_d;
      rx_nums_q  <= rx_nums_d;
      rx_avail_q <= rx_avail_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_msb_d   = rx_msb_q;
    rx_half_d  = rx_half_q;
    rx_k_d     = rx_k_q;
    rx_nums_d  = rx_nums_q;
    rx_avail_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (!rx_s2_q) begin
            // Framing error: drop the byte and resynchronise pairing on the next MSB.
            rx_half_d = 1'b0;
          end else if (!rx_half_q) begin
            rx_msb_d  = rx_shift_q;
            rx_half_d = 1'b1;
          end else begin
            rx_half_d = 1'b0;
            for (int s = 0; s < N_RX_NUMS; s++) begin
              if (rx_k_q == KW'(s)) rx_nums_d[16*s +: 16] = {rx_msb_q, rx_shift_q};
            end
            if (rx_k_q == K_LAST) begin
              rx_k_d     = '0;
              rx_avail_d = 1'b1;
            end else begin
              rx_k_d = rx_k_q + 1'b1;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  assign rx_nums      = rx_nums_q;
  assign rx_available = rx_avail_q;

endmodule

// File: tb/tb_senone_serial_link.sv
// tb/tb_senone_serial_link.sv - randomized bench for senone_serial_link against a queue/array model
// Model tracks expected reads, expected TX bytes and RX slot contents at the word level.
module tb_senone_serial_link;

  localparam int CPB = 16;
  localparam int NS  = 5;
  localparam int NR  = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_send = 1'b0;
  logic              send_done;
  logic [20:0]       sram_addr;
  logic              read_data;
  logic              sram_ready = 1'b1;
  logic [15:0]       data_in = '0;
  logic              tx;
  logic              rx_line;
  logic              rx_bench = 1'b1;
  logic              loop_en = 1'b0;
  logic [16*NR-1:0]  rx_nums;
  logic              rx_available;

  assign rx_line = loop_en ? tx : rx_bench;

  senone_serial_link #(
    .N_SENONES(NS), .BASE_ADDR(21'd0), .CLKS_PER_BIT(CPB), .N_RX_NUMS(NR)
  ) dut (
    .clk(clk), .reset(reset), .start_send(start_send), .send_done(send_done),
    .sram_addr(sram_addr), .read_data(read_data), .sram_ready(sram_ready),
    .data_in(data_in), .tx(tx), .rx(rx_line), .rx_nums(rx_nums),
    .rx_available(rx_available)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: condition false at cycle %0d", name, cyc_cnt);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- model state ----------------
  bit          sending = 0;
  int          nreads = 0;
  bit          pend = 0;
  logic [7:0]  exp_tx[$];
  int          done_cnt = 0;
  int          tx_bytes_seen = 0;
  logic [7:0]  first_byte = '0;
  logic [15:0] m_slots[NR];
  int          m_k = 0;
  bit          m_half = 0;
  logic [7:0]  m_msb = '0;
  int          m_avail = 0;
  int          dut_avail = 0;
  bit          avail_prev = 0;

  task automatic model_rx_reset();
    for (int s = 0; s < NR; s++) m_slots[s] = '0;
    m_k = 0;
    m_half = 0;
  endtask

  task automatic model_rx_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_half = 0;
    end else if (!m_half) begin
      m_msb = b;
      m_half = 1;
    end else begin
      m_slots[m_k] = {m_msb, b};
      m_half = 0;
      if (m_k == NR - 1) begin
        m_k = 0;
        m_avail++;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic check_all_slots(input string name);
    for (int s = 0; s < NR; s++) check_eq(name, {16'h0, rx_nums[16*s +: 16]}, {16'h0, m_slots[s]});
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      sending = 0;
      nreads = 0;
      pend = 0;
      exp_tx.delete();
      model_rx_reset();
      avail_prev = 0;
    end else begin
      if (read_data) begin
        check_true("read_while_idle", sending);
        check_eq("sram_addr", {11'h0, sram_addr}, nreads);
        if (sram_ready) begin
          exp_tx.push_back(data_in[15:8]);
          exp_tx.push_back(data_in[7:0]);
          nreads++;
          pend = 0;
        end else begin
          pend = 1;
        end
      end else begin
        check_true("read_dropped_before_ready", !pend);
        if (!sending) check_eq("tx_idle_high", {31'h0, tx}, 32'h1);
      end
      if (send_done) begin
        check_true("send_done_spurious", sending);
        check_eq("reads_per_send", nreads, NS);
        check_eq("tx_bytes_left_at_done", exp_tx.size(), 0);
        sending = 0;
        done_cnt++;
      end
      if (start_send && !sending) begin
        sending = 1;
        nreads = 0;
      end
      if (rx_available) begin
        check_true("rx_available_width", !avail_prev);
        dut_avail++;
        check_all_slots("rx_slot_at_available");
      end
      avail_prev = rx_available;
    end
  end

  // ---------------- UART TX monitor ----------------
  bit          mon_busy = 0;
  int          mon_cnt = 0;
  logic [9:0]  mon_bits = '0;
  logic        tx_prev = 1'b1;
  logic [7:0]  mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_busy = 0;
      tx_prev = 1'b1;
    end else begin
      if (!mon_busy) begin
        if (tx_prev && !tx) begin
          mon_busy = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_busy && (mon_cnt % CPB) == CPB / 2) begin
        mon_bits[mon_cnt / CPB] = tx;
        if (mon_cnt / CPB == 9) begin
          mon_busy = 0;
          check_eq("tx_start_bit", {31'h0, mon_bits[0]}, 32'h0);
          check_eq("tx_stop_bit", {31'h0, mon_bits[9]}, 32'h1);
          if (exp_tx.size() == 0) begin
            check_true("tx_unexpected_byte", 1'b0);
          end else begin
            mon_exp = exp_tx.pop_front();
            check_eq("tx_byte", {24'h0, mon_bits[8:1]}, {24'h0, mon_exp});
            if (tx_bytes_seen == 0) first_byte = mon_bits[8:1];
            tx_bytes_seen++;
            if (loop_en) model_rx_byte(mon_exp, 1'b1);
          end
        end
      end
      tx_prev = tx;
    end
  end

  // ---------------- SRAM responder ----------------
  int          rdy_mode = 0;
  bit          data_rand = 0;
  logic [15:0] data_const = 16'h0;
  int          stall_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_in = data_rand ? 16'($urandom) : data_const;
      case (rdy_mode)
        1: sram_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (read_data && sram_addr == 21'd2 && stall_cnt < 7) begin
            sram_ready = 1'b0;
            stall_cnt++;
          end else begin
            sram_ready = 1'b1;
          end
        end
        default: sram_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start_send = 1'b1;
    cyc(1);
    start_send = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (send_done) begin
        at = cyc_cnt;
        break;
      end
    end
    check_true("send_done_timeout", at >= 0);
    cyc(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx_bench = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_bench = b[i];
      cyc(CPB);
    end
    rx_bench = stop_ok;
    cyc(CPB / 2);
    model_rx_byte(b, stop_ok);
    cyc(CPB - CPB / 2);
    rx_bench = 1'b1;
    cyc($urandom_range(1, CPB));
  endtask

  // ---------------- main sequence ----------------
  int t_start, t_done, done_before;
  logic [15:0] w;

  initial begin
    model_rx_reset();
    cyc(3);
    @(negedge clk);
    check_eq("reset_tx", {31'h0, tx}, 32'h1);
    check_eq("reset_send_done", {31'h0, send_done}, 32'h0);
    check_eq("reset_read_data", {31'h0, read_data}, 32'h0);
    check_eq("reset_sram_addr", {11'h0, sram_addr}, 32'h0);
    check_true("reset_rx_nums", rx_nums == '0);
    check_eq("reset_rx_available", {31'h0, rx_available}, 32'h0);
    cyc(1);
    reset = 1'b0;

    // T1: constant 55AA, always ready
    data_const = 16'h55aa;
    rdy_mode = 0;
    cyc(2);
    t_start = cyc_cnt;
    pulse_start();
    wait_done(3000, t_done);
    check_true("t1_latency", (t_done - t_start) >= 100 * CPB && (t_done - t_start) <= 100 * CPB + 40);
    check_eq("t1_bytes_seen", tx_bytes_seen, 10);
    check_eq("t1_first_byte", {24'h0, first_byte}, 32'h55);
    check_eq("t1_done_count", done_cnt, 1);
    cyc(5);

    // T2 + T3: SRAM stall on word 2, redundant start mid-transfer
    data_rand = 1;
    rdy_mode = 2;
    stall_cnt = 0;
    pulse_start();
    cyc(700);
    pulse_start();
    wait_done(4000, t_done);
    check_eq("t2_stall_cycles", stall_cnt, 7);
    cyc(400);
    check_eq("t3_done_count", done_cnt, 2);

    // random SRAM readiness and data
    rdy_mode = 1;
    for (int s = 0; s < 2; s++) begin
      pulse_start();
      cyc($urandom_range(50, 900));
      pulse_start();
      wait_done(6000, t_done);
      cyc($urandom_range(3, 20));
    end
    check_eq("rand_done_count", done_cnt, 4);

    // T4: loopback of 8001 words
    rdy_mode = 0;
    data_rand = 0;
    data_const = 16'h8001;
    loop_en = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pulse_start();
      wait_done(3000, t_done);
      cyc(5);
    end
    cyc(50);
    for (int s = 0; s < NR; s++) check_eq("t4_slot", {16'h0, rx_nums[16*s +: 16]}, 32'h8001);
    check_eq("t4_available_count", dut_avail, 1);
    check_eq("t4_model_available", m_avail, 1);
    loop_en = 1'b0;
    cyc(5);

    // T5: glitch and framing error, then a valid pair into slot 0
    send_frame(8'h12, 1'b1);
    rx_bench = 1'b0;
    cyc(CPB / 4);
    rx_bench = 1'b1;
    cyc(2 * CPB);
    send_frame(8'h34, 1'b0);
    send_frame(8'hab, 1'b1);
    send_frame(8'hcd, 1'b1);
    cyc(2 * CPB);
    check_eq("t5_slot0", {16'h0, rx_nums[15:0]}, 32'habcd);
    check_eq("t5_slot1", {16'h0, rx_nums[31:16]}, 32'h8001);
    check_eq("t5_available_count", dut_avail, 1);
    check_all_slots("t5_slots");

    // random RX words with occasional framing errors
    for (int n = 0; n < 12; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 4) == 0) send_frame(8'($urandom), 1'b0);
      send_frame(w[15:8], 1'b1);
      send_frame(w[7:0], 1'b1);
    end
    cyc(2 * CPB);
    check_all_slots("rand_rx_slots");
    check_eq("rand_rx_available", dut_avail, m_avail);

    // T6: reset mid-frame
    data_rand = 1;
    done_before = done_cnt;
    pulse_start();
    t_done = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx) begin
        t_done = i;
        break;
      end
    end
    check_true("t6_frame_start_timeout", t_done >= 0);
    cyc(5 * CPB);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_tx_after_reset", {31'h0, tx}, 32'h1);
    check_true("t6_rx_nums_cleared", rx_nums == '0);
    cyc(1);
    reset = 1'b0;
    cyc(2000);
    check_eq("t6_no_done_after_reset", done_cnt, done_before);
    pulse_start();
    wait_done(3000, t_done);
    check_eq("t6_done_after_restart", done_cnt, done_before + 1);
    cyc(20);
    check_eq("final_done_count", done_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
